// File: rtl/square_fall_ctl_pkg.sv
// Common widths and helpers for the falling-square motion controller.
package square_fall_ctl_pkg;
  localparam int POS_W = 12;
  localparam int VEL_W = 6;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                 input logic [POS_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/vga_pkg.sv
// Shared VGA display geometry for the 1024x768 timing used across the video path.
package vga_pkg;
  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
endpackage

// File: rtl/vga_if.sv
// VGA timing bundle passed between the timing generator and the draw pipeline.
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport sink (input hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/square_fall_ctl_tick.sv
// frame_tick: one-clock pulse on each rising edge of vblnk (once per frame).
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic tick
);
  logic vblnk_q;
  logic vblnk_d;

  always_comb vblnk_d = vblnk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vblnk_q <= 1'b0;
    else     vblnk_q <= vblnk_d;
  end

  assign tick = vblnk & ~vblnk_q;
endmodule

// File: rtl/square_fall_ctl.sv
// Square motion controller: mouse tracking, per-frame gravity fall, landing.
// Optional rebound behaviour is enabled with `define SQUARE_BOUNCE_EN.
module square_fall_ctl
  import vga_pkg::*;
  import square_fall_ctl_pkg::*;
#(
  parameter int SIZE  = 64,
  parameter int ACCEL = 1,
  parameter int VMAX  = 16
`ifdef SQUARE_BOUNCE_EN
  ,
  parameter int MIN_BOUNCE = 2
`endif
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.sink         vga_in,
  input  logic        mouse_right,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [11:0] xpos_square,
  output logic [11:0] ypos_square,
  output logic [11:0] width_square,
  output logic        busy
);
  localparam logic [POS_W-1:0] BOTTOM  = POS_W'(VER_PIXELS - SIZE);
  localparam logic [POS_W-1:0] RIGHT   = POS_W'(HOR_PIXELS - SIZE);
  localparam logic [VEL_W-1:0] VMAX_V  = VEL_W'(VMAX);
  localparam logic [VEL_W-1:0] ACCEL_V = VEL_W'(ACCEL);

`ifdef SQUARE_BOUNCE_EN
  localparam logic [VEL_W-1:0] MIN_B = VEL_W'(MIN_BOUNCE);
  typedef enum logic [1:0] {IDLE = 2'd0, FALLING = 2'd1, LANDED = 2'd2, RISING = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FALLING = 2'd1, LANDED = 2'd2} state_e;
`endif

  // Internal reset asserts with rst and releases two clocks after it drops.
  logic [1:0] rst_pipe_q;
  logic [1:0] rst_pipe_d;
  logic       rst_int;

  always_comb rst_pipe_d = {rst_pipe_q[0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe_q <= 2'b11;
    else     rst_pipe_q <= rst_pipe_d;
  end

  assign rst_int = rst_pipe_q[1];

  logic right_meta_q, right_sync_q, right_prev_q;
  logic click, tick;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      right_meta_q <= 1'b0;
      right_sync_q <= 1'b0;
      right_prev_q <= 1'b0;
    end else begin
      right_meta_q <= mouse_right;
      right_sync_q <= right_meta_q;
      right_prev_q <= right_sync_q;
    end
  end

  assign click = right_sync_q & ~right_prev_q;

  frame_tick u_frame_tick (
    .clk   (clk),
    .rst   (rst_int),
    .vblnk (vga_in.vblnk),
    .tick  (tick)
  );

  state_e             state_q, state_d;
  logic [POS_W-1:0]   xpos_q, xpos_d, ypos_q, ypos_d;
  logic [VEL_W-1:0]   vel_q, vel_d;
  logic               busy_q, busy_d;
  logic [VEL_W:0]     vel_sum;
  logic [VEL_W-1:0]   vel_inc;
  logic [POS_W-1:0]   ynext;
`ifdef SQUARE_BOUNCE_EN
  logic [VEL_W-1:0]   rv, vel_dec;
  logic [POS_W-1:0]   yup;
`endif

  always_comb begin
    vel_sum = {1'b0, vel_q} + (VEL_W+1)'(ACCEL_V);
    vel_inc = (vel_sum > (VEL_W+1)'(VMAX_V)) ? VMAX_V : vel_sum[VEL_W-1:0];
    ynext   = ypos_q + POS_W'(vel_inc);
`ifdef SQUARE_BOUNCE_EN
    rv      = vel_inc >> 1;
    vel_dec = (vel_q >= ACCEL_V) ? vel_q - ACCEL_V : '0;
    yup     = (ypos_q >= POS_W'(vel_q)) ? ypos_q - POS_W'(vel_q) : '0;
`endif

    state_d = state_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    vel_d   = vel_q;

    case (state_q)
      IDLE: begin
        xpos_d = clamp_pos(mouse_xpos, RIGHT);
        ypos_d = clamp_pos(mouse_ypos, BOTTOM);
        vel_d  = '0;
        if (click) state_d = FALLING;
      end
      FALLING: begin
        if (tick) begin
          vel_d = vel_inc;
          if (ynext >= BOTTOM) begin
            ypos_d  = BOTTOM;
            state_d = LANDED;
            vel_d   = '0;
`ifdef SQUARE_BOUNCE_EN
            if (rv >= MIN_B) begin
              state_d = RISING;
              vel_d   = rv;
            end
`endif
          end else begin
            ypos_d = ynext;
          end
        end
      end
      LANDED: begin
        ypos_d = BOTTOM;
        vel_d  = '0;
        if (click) state_d = IDLE;
      end
`ifdef SQUARE_BOUNCE_EN
      RISING: begin
        if (tick) begin
          ypos_d = yup;
          vel_d  = vel_dec;
          if (vel_dec == '0) state_d = FALLING;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q <= IDLE;
      xpos_q  <= '0;
      ypos_q  <= '0;
      vel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      vel_q   <= vel_d;
      busy_q  <= busy_d;
    end
  end

  assign xpos_square  = xpos_q;
  assign ypos_square  = ypos_q;
  assign width_square = POS_W'(SIZE);
  assign busy         = busy_q;
endmodule

// File: tb/tb_square_fall_ctl.sv
// Directed bench for square_fall_ctl: tracking, clamping, fall profile, clicks, reset.
module tb_square_fall_ctl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mouse_right = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic [11:0] xpos_square, ypos_square, width_square;
  logic        busy;
  int          checks = 0;
  int          failures = 0;

  vga_if vga_bus ();

  square_fall_ctl dut (
    .clk          (clk),
    .rst          (rst),
    .vga_in       (vga_bus),
    .mouse_right  (mouse_right),
    .mouse_xpos   (mouse_xpos),
    .mouse_ypos   (mouse_ypos),
    .xpos_square  (xpos_square),
    .ypos_square  (ypos_square),
    .width_square (width_square),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic int exp_fall(input int k);
    int y;
    y = (k <= 16) ? k * (k + 1) / 2 : 136 + 16 * (k - 16);
    return (y >= 704) ? 704 : y;
  endfunction

  task automatic do_tick();
    @(negedge clk) vga_bus.vblnk = 1'b1;
    repeat (2) @(negedge clk);
    vga_bus.vblnk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_click();
    @(negedge clk) mouse_right = 1'b1;
    repeat (4) @(negedge clk);
    mouse_right = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Click pulse and tick pulse land on the same clock edge.
  task automatic click_with_tick();
    @(negedge clk) mouse_right = 1'b1;
    repeat (2) @(negedge clk);
    vga_bus.vblnk = 1'b1;
    repeat (2) @(negedge clk);
    vga_bus.vblnk = 1'b0;
    mouse_right = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic apply_reset(input int x, input int y);
    @(negedge clk) rst = 1'b1;
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mouse_xpos = 12'd100;
    mouse_ypos = 12'd200;
    repeat (3) @(negedge clk);
    checks++;
    if (xpos_square !== 12'd0 || ypos_square !== 12'd0 || busy !== 1'b0 || width_square !== 12'd64) begin
      failures++;
      $display("FAIL reset_state: x=%0d y=%0d busy=%b w=%0d expected x=0 y=0 busy=0 w=64",
               xpos_square, ypos_square, busy, width_square);
    end
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (xpos_square !== 12'd100 || ypos_square !== 12'd200 || busy !== 1'b0 || width_square !== 12'd64) begin
      failures++;
      $display("FAIL track_after_reset: x=%0d y=%0d busy=%b w=%0d expected x=100 y=200 busy=0 w=64",
               xpos_square, ypos_square, busy, width_square);
    end
  endtask

  task automatic test_clamp();
    int mx[5] = '{1000, 960, 961, 0, 4095};
    int my[5] = '{750, 704, 705, 0, 4095};
    int ex[5] = '{960, 960, 960, 0, 960};
    int ey[5] = '{704, 704, 704, 0, 704};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mouse_xpos = 12'(mx[i]);
      mouse_ypos = 12'(my[i]);
      repeat (2) @(negedge clk);
      checks++;
      if (xpos_square !== 12'(ex[i]) || ypos_square !== 12'(ey[i])) begin
        failures++;
        $display("FAIL clamp[%0d]: x=%0d y=%0d expected x=%0d y=%0d",
                 i, xpos_square, ypos_square, ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_fall();
    apply_reset(300, 0);
    do_click();
    checks++;
    if (busy !== 1'b1 || xpos_square !== 12'd300 || ypos_square !== 12'd0) begin
      failures++;
      $display("FAIL fall_start: x=%0d y=%0d busy=%b expected x=300 y=0 busy=1",
               xpos_square, ypos_square, busy);
    end
    mouse_xpos = 12'd500;
    mouse_ypos = 12'd500;
    for (int k = 1; k <= 52; k++) begin
      do_tick();
      checks++;
      if (ypos_square !== 12'(exp_fall(k))) begin
        failures++;
        $display("FAIL fall_tick%0d: y=%0d expected %0d", k, ypos_square, exp_fall(k));
      end
    end
    checks++;
    if (xpos_square !== 12'd300 || busy !== 1'b1) begin
      failures++;
      $display("FAIL fall_xhold: x=%0d busy=%b expected x=300 busy=1", xpos_square, busy);
    end
`ifndef SQUARE_BOUNCE_EN
    do_tick();
    do_tick();
    checks++;
    if (ypos_square !== 12'd704 || busy !== 1'b1 || xpos_square !== 12'd300) begin
      failures++;
      $display("FAIL landed_hold: x=%0d y=%0d busy=%b expected x=300 y=704 busy=1",
               xpos_square, ypos_square, busy);
    end
    do_click();
    checks++;
    if (busy !== 1'b0 || xpos_square !== 12'd500 || ypos_square !== 12'd500) begin
      failures++;
      $display("FAIL landed_click: x=%0d y=%0d busy=%b expected x=500 y=500 busy=0",
               xpos_square, ypos_square, busy);
    end
`endif
  endtask

  task automatic test_clicks_ignored();
    apply_reset(300, 0);
    click_with_tick();
    checks++;
    if (busy !== 1'b1 || ypos_square !== 12'd0) begin
      failures++;
      $display("FAIL click_wins: y=%0d busy=%b expected y=0 busy=1", ypos_square, busy);
    end
    for (int k = 1; k <= 20; k++) begin
      if (k % 3 == 0) click_with_tick();
      else            do_tick();
      checks++;
      if (ypos_square !== 12'(exp_fall(k)) || busy !== 1'b1) begin
        failures++;
        $display("FAIL midfall_tick%0d: y=%0d busy=%b expected y=%0d busy=1",
                 k, ypos_square, busy, exp_fall(k));
      end
    end
    do_click();
    checks++;
    if (ypos_square !== 12'(exp_fall(20)) || busy !== 1'b1 || xpos_square !== 12'd300) begin
      failures++;
      $display("FAIL midfall_click: x=%0d y=%0d busy=%b expected x=300 y=%0d busy=1",
               xpos_square, ypos_square, busy, exp_fall(20));
    end
  endtask

  task automatic test_reset_mid_fall();
    apply_reset(300, 0);
    do_click();
    for (int k = 1; k <= 10; k++) do_tick();
    checks++;
    if (ypos_square !== 12'd55) begin
      failures++;
      $display("FAIL pre_reset_y: y=%0d expected 55", ypos_square);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (xpos_square !== 12'd0 || ypos_square !== 12'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: x=%0d y=%0d busy=%b expected x=0 y=0 busy=0",
               xpos_square, ypos_square, busy);
    end
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    do_tick();
    checks++;
    if (xpos_square !== 12'd300 || ypos_square !== 12'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: x=%0d y=%0d busy=%b expected x=300 y=0 busy=0",
               xpos_square, ypos_square, busy);
    end
  endtask

`ifdef SQUARE_BOUNCE_EN
  task automatic test_bounce();
    int seq[31] = '{696, 689, 683, 678, 674, 671, 669, 668,
                    669, 671, 674, 678, 683, 689, 696, 704,
                    700, 697, 695, 694,
                    695, 697, 700, 704,
                    702, 701,
                    702, 704,
                    704, 704, 704};
    apply_reset(300, 0);
    do_click();
    for (int k = 1; k <= 52; k++) do_tick();
    for (int i = 0; i < 31; i++) begin
      do_tick();
      checks++;
      if (ypos_square !== 12'(seq[i]) || busy !== 1'b1) begin
        failures++;
        $display("FAIL bounce[%0d]: y=%0d busy=%b expected y=%0d busy=1",
                 i, ypos_square, busy, seq[i]);
      end
    end
    do_click();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL bounce_landed_click: busy=%b expected 0", busy);
    end
  endtask
`endif

  initial begin
    vga_bus.hcount = '0;
    vga_bus.vcount = '0;
    vga_bus.hsync  = 1'b0;
    vga_bus.vsync  = 1'b0;
    vga_bus.hblnk  = 1'b0;
    vga_bus.vblnk  = 1'b0;
    test_reset();
    test_clamp();
    test_fall();
    test_clicks_ignored();
    test_reset_mid_fall();
`ifdef SQUARE_BOUNCE_EN
    test_bounce();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
